// File: rtl/srambus_arbiter_pkg.sv
// Shared constants for the SRAM bus arbiter: default widths, access-size codes and master ids.
package srambus_arbiter_pkg;

   localparam int unsigned AW_DEF          = 32;
   localparam int unsigned DW_DEF          = 32;
   localparam int unsigned MW_DEF          = 4;
   localparam int unsigned OUTSTANDING_DEF = 2;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   typedef enum logic {
      ID_IF  = 1'b0,
      ID_LSU = 1'b1
   } master_id_e;

endpackage

// File: rtl/srambus_owner_fifo.sv
// In-order queue of master ids for accepted transactions; head names the owner of the next response.
module srambus_owner_fifo #(
   parameter int unsigned Depth = 2,
   localparam int unsigned CW   = $clog2(Depth + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          din,
   output logic          dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Depth-1:0] mem_q, mem_d;
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CW'(Depth));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) begin
         mem_d[wptr_q] = din;
         wptr_d        = wrap_inc(wptr_q);
      end
      if (do_pop) begin
         rptr_d = wrap_inc(rptr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/srambus_arbiter.sv
// Two-master round-robin arbiter onto one split-handshake SRAM port; responses are routed
// back to their issuer through an in-order owner queue.
module srambus_arbiter
   import srambus_arbiter_pkg::*;
#(
   parameter int unsigned AW          = AW_DEF,
   parameter int unsigned DW          = DW_DEF,
   parameter int unsigned MW          = MW_DEF,
   parameter int unsigned OUTSTANDING = OUTSTANDING_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [1:0]    m0_size,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [MW-1:0] m0_wem,
   output logic          m0_addr_ok,
   output logic          m0_data_ok,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [1:0]    m1_size,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic [MW-1:0] m1_wem,
   output logic          m1_addr_ok,
   output logic          m1_data_ok,
   output logic [DW-1:0] m1_rdata,
   output logic          s_req,
   output logic          s_we,
   output logic [1:0]    s_size,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   output logic [MW-1:0] s_wem,
   input  logic          s_addr_ok,
   input  logic          s_data_ok,
   input  logic [DW-1:0] s_rdata,
   output logic          err
);

   localparam int unsigned CW = $clog2(OUTSTANDING + 1);

   master_id_e    rr_last_q, rr_last_d, winner;
   logic          err_q, err_d;
   logic          gnt_vld, accept, resp;
   logic          q_full, q_empty, owner;
   logic [CW-1:0] q_count;

   srambus_owner_fifo #(
      .Depth (OUTSTANDING)
   ) u_owner_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .pop   (resp),
      .din   (winner),
      .dout  (owner),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   // Grant depends only on requests, queue occupancy and rr_last, never on data_ok.
   always_comb begin
      gnt_vld = rst_n & ~q_full & (m0_req | m1_req);
      if (m0_req & m1_req) begin
         winner = (rr_last_q == ID_IF) ? ID_LSU : ID_IF;
      end else if (m1_req) begin
         winner = ID_LSU;
      end else begin
         winner = ID_IF;
      end

      s_req   = 1'b0;
      s_we    = 1'b0;
      s_size  = '0;
      s_addr  = '0;
      s_wdata = '0;
      s_wem   = '0;
      if (gnt_vld) begin
         s_req = 1'b1;
         if (winner == ID_LSU) begin
            s_we    = m1_we;
            s_size  = m1_size;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wem   = m1_wem;
         end else begin
            s_we    = m0_we;
            s_size  = m0_size;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wem   = m0_wem;
         end
      end

      accept     = s_req & s_addr_ok;
      m0_addr_ok = accept & (winner == ID_IF);
      m1_addr_ok = accept & (winner == ID_LSU);

      resp       = rst_n & s_data_ok & (q_count != '0);
      m0_data_ok = resp & (owner == ID_IF);
      m1_data_ok = resp & (owner == ID_LSU);
      m0_rdata   = m0_data_ok ? s_rdata : '0;
      m1_rdata   = m1_data_ok ? s_rdata : '0;

      rr_last_d  = accept ? winner : rr_last_q;
      // A response with nothing outstanding is a slave protocol violation; latch it.
      err_d      = err_q | (s_data_ok & q_empty);
   end

   assign err = err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_last_q <= ID_IF;
         err_q     <= 1'b0;
      end else begin
         rr_last_q <= rr_last_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_srambus_arbiter.sv
// Directed and randomized checks of srambus_arbiter against a queue-based reference model.
module tb_srambus_arbiter;
   import srambus_arbiter_pkg::*;

   localparam int unsigned OUT = 2;

   logic        clk, rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [1:0]  m0_size, m1_size, s_size;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
   logic [3:0]  m0_wem, m1_wem, s_wem;
   logic        m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok;
   logic        s_req, s_we, s_addr_ok, s_data_ok, err;
   logic [31:0] s_addr, s_wdata, s_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic        owner;
      logic [31:0] rdata;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [31:0] mem [logic [31:0]];

   srambus_arbiter #(
      .AW (32), .DW (32), .MW (4), .OUTSTANDING (OUT)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .m0_req (m0_req), .m0_we (m0_we), .m0_size (m0_size), .m0_addr (m0_addr),
      .m0_wdata (m0_wdata), .m0_wem (m0_wem), .m0_addr_ok (m0_addr_ok),
      .m0_data_ok (m0_data_ok), .m0_rdata (m0_rdata),
      .m1_req (m1_req), .m1_we (m1_we), .m1_size (m1_size), .m1_addr (m1_addr),
      .m1_wdata (m1_wdata), .m1_wem (m1_wem), .m1_addr_ok (m1_addr_ok),
      .m1_data_ok (m1_data_ok), .m1_rdata (m1_rdata),
      .s_req (s_req), .s_we (s_we), .s_size (s_size), .s_addr (s_addr),
      .s_wdata (s_wdata), .s_wem (s_wem), .s_addr_ok (s_addr_ok),
      .s_data_ok (s_data_ok), .s_rdata (s_rdata), .err (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_we = 1'b0; m0_size = SIZE_W; m0_addr = '0; m0_wdata = '0; m0_wem = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_size = SIZE_W; m1_addr = '0; m1_wdata = '0; m1_wem = '0;
      s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] wem);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) if (wem[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   initial begin
      logic        w, o, a0, a1, rr, full, wv, win, acc, own;
      logic [7:0]  ok_mask, dok_mask;
      logic [31:0] merged, rd, ad;

      // Reset with both masters and the slave active: nothing may be acknowledged.
      rst_n = 1'b0;
      idle_inputs();
      m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
      next_cycle();
      #2;
      chk("rst_m0_addr_ok", m0_addr_ok, 0);
      chk("rst_m1_addr_ok", m1_addr_ok, 0);
      chk("rst_m0_data_ok", m0_data_ok, 0);
      chk("rst_m1_data_ok", m1_data_ok, 0);
      chk("rst_err", err, 0);
      next_cycle();
      idle_inputs();
      rst_n = 1'b1;

      // Single m0 read.
      m0_req = 1'b1; m0_addr = 32'h100; s_addr_ok = 1'b1;
      #2;
      chk("a_m0_addr_ok", m0_addr_ok, 1);
      chk("a_m1_addr_ok", m1_addr_ok, 0);
      chk("a_s_req", s_req, 1);
      chk("a_s_addr", s_addr, 32'h100);
      chk("a_m0_data_ok_early", m0_data_ok, 0);
      next_cycle();
      idle_inputs();
      s_data_ok = 1'b1; s_rdata = 32'hDEADBEEF;
      #2;
      chk("a_m0_data_ok", m0_data_ok, 1);
      chk("a_m0_rdata", m0_rdata, 32'hDEADBEEF);
      chk("a_m1_data_ok", m1_data_ok, 0);
      chk("a_m1_rdata", m1_rdata, 0);
      next_cycle();
      idle_inputs();

      // Round-robin from reset: m1, m0, m1, m0.
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         idle_inputs();
         if (c < 4) begin
            m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h200; m1_addr = 32'h300;
            s_addr_ok = 1'b1;
         end
         if (c > 0) begin
            s_data_ok = 1'b1; s_rdata = 32'hA000_0000 + 32'(c);
         end
         #2;
         if (c < 4) begin
            w = (c % 2 == 0);
            chk("b_m1_addr_ok", m1_addr_ok, w);
            chk("b_m0_addr_ok", m0_addr_ok, !w);
            chk("b_s_addr", s_addr, w ? 32'h300 : 32'h200);
         end
         if (c > 0) begin
            o = ((c - 1) % 2 == 0);
            chk("b_m1_data_ok", m1_data_ok, o);
            chk("b_m0_data_ok", m0_data_ok, !o);
         end
         next_cycle();
      end

      // Queue full: third request stalls until the first response has popped.
      ok_mask  = 8'b0001_0011;
      dok_mask = 8'b1001_1000;
      for (int c = 0; c < 8; c++) begin
         idle_inputs();
         if (c <= 4) begin
            m0_req = 1'b1; m0_addr = 32'h500;
         end
         s_addr_ok = 1'b1;
         if (dok_mask[c]) begin
            s_data_ok = 1'b1; s_rdata = 32'hC0 + 32'(c);
         end
         #2;
         chk("c_m0_addr_ok", m0_addr_ok, ok_mask[c]);
         chk("c_s_req", s_req, ok_mask[c]);
         chk("c_m0_data_ok", m0_data_ok, dok_mask[c]);
         if (dok_mask[c]) chk("c_m0_rdata", m0_rdata, 32'hC0 + 32'(c));
         next_cycle();
      end

      // Masked write by m1 followed by an m0 read of the same word.
      merged = merge(32'hAABBCCDD, 32'h11223344, 4'b0011);
      idle_inputs();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h11223344; m1_wem = 4'b0011;
      s_addr_ok = 1'b1;
      #2;
      chk("d_m1_addr_ok", m1_addr_ok, 1);
      chk("d_s_we", s_we, 1);
      chk("d_s_wem", s_wem, 4'b0011);
      chk("d_s_wdata", s_wdata, 32'h11223344);
      chk("d_s_addr", s_addr, 32'h40);
      next_cycle();
      idle_inputs();
      m0_req = 1'b1; m0_addr = 32'h40; s_addr_ok = 1'b1; s_data_ok = 1'b1;
      #2;
      chk("d_m0_addr_ok", m0_addr_ok, 1);
      chk("d_s_we_read", s_we, 0);
      chk("d_m1_data_ok", m1_data_ok, 1);
      chk("d_m0_data_ok_early", m0_data_ok, 0);
      next_cycle();
      idle_inputs();
      s_data_ok = 1'b1; s_rdata = merged;
      #2;
      chk("d_m0_data_ok", m0_data_ok, 1);
      chk("d_m0_rdata", m0_rdata, 32'hAABB3344);
      chk("d_m1_data_ok_late", m1_data_ok, 0);
      next_cycle();

      // Response with nothing outstanding.
      idle_inputs();
      s_data_ok = 1'b1; s_rdata = 32'h55;
      #2;
      chk("e_m0_data_ok", m0_data_ok, 0);
      chk("e_m1_data_ok", m1_data_ok, 0);
      chk("e_err_before", err, 0);
      next_cycle();
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         #2;
         chk("e_err_held", err, 1);
         next_cycle();
      end
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      #2;
      chk("e_err_clr", err, 0);
      next_cycle();

      // Reset with two outstanding: rr_last left at m1, both entries must be dropped.
      m0_req = 1'b1; m0_addr = 32'h600; s_addr_ok = 1'b1;
      #2;
      chk("f_m0_addr_ok_pre", m0_addr_ok, 1);
      next_cycle();
      idle_inputs();
      m1_req = 1'b1; m1_addr = 32'h700; s_addr_ok = 1'b1;
      #2;
      chk("f_m1_addr_ok_pre", m1_addr_ok, 1);
      next_cycle();
      rst_n = 1'b0;
      m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h800; m1_addr = 32'h900;
      #2;
      chk("f_rst_m0_addr_ok", m0_addr_ok, 0);
      chk("f_rst_m1_addr_ok", m1_addr_ok, 0);
      next_cycle();
      rst_n = 1'b1;
      #2;
      chk("f_tie_m1_addr_ok", m1_addr_ok, 1);
      chk("f_tie_m0_addr_ok", m0_addr_ok, 0);
      chk("f_no_stale_m0", m0_data_ok, 0);
      chk("f_no_stale_m1", m1_data_ok, 0);
      next_cycle();
      m1_req = 1'b0;
      #2;
      chk("f_second_m0_addr_ok", m0_addr_ok, 1);
      next_cycle();
      m0_addr = 32'hA00;
      #2;
      chk("f_full_m0_addr_ok", m0_addr_ok, 0);
      chk("f_full_s_req", s_req, 0);
      next_cycle();
      idle_inputs();
      s_data_ok = 1'b1; s_rdata = 32'h77;
      #2;
      chk("f_rsp1_m1_data_ok", m1_data_ok, 1);
      chk("f_rsp1_m0_data_ok", m0_data_ok, 0);
      next_cycle();
      #2;
      chk("f_rsp2_m0_data_ok", m0_data_ok, 1);
      chk("f_rsp2_m1_data_ok", m1_data_ok, 0);
      chk("f_err", err, 0);
      next_cycle();

      // Randomized traffic against the reference model.
      idle_inputs();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      a0 = 1'b0; a1 = 1'b0; rr = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!a0 && $urandom_range(0, 1) == 1) begin
            a0 = 1'b1;
            m0_addr = 32'($urandom_range(0, 15)) << 2;
            m0_size = SIZE_W;
         end
         if (!a1 && $urandom_range(0, 1) == 1) begin
            a1 = 1'b1;
            m1_we    = 1'($urandom_range(0, 1));
            m1_addr  = 32'($urandom_range(0, 15)) << 2;
            m1_size  = 2'($urandom_range(0, 2));
            m1_wdata = $urandom;
            m1_wem   = 4'($urandom_range(1, 15));
         end
         m0_req    = a0;
         m1_req    = a1;
         s_addr_ok = ($urandom_range(0, 3) != 0);
         s_data_ok = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
         own       = (exp_q.size() > 0) ? exp_q[0].owner : 1'b0;
         s_rdata   = s_data_ok ? exp_q[0].rdata : $urandom;

         full = (exp_q.size() == OUT);
         wv   = !full && (a0 || a1);
         win  = (a0 && a1) ? !rr : a1;
         acc  = wv && s_addr_ok;
         #2;
         chk("r_s_req", s_req, wv);
         chk("r_m0_addr_ok", m0_addr_ok, acc && !win);
         chk("r_m1_addr_ok", m1_addr_ok, acc && win);
         if (wv) begin
            chk("r_s_addr", s_addr, win ? m1_addr : m0_addr);
            chk("r_s_we", s_we, win ? m1_we : m0_we);
            chk("r_s_size", s_size, win ? m1_size : m0_size);
         end
         chk("r_m0_data_ok", m0_data_ok, s_data_ok && !own);
         chk("r_m1_data_ok", m1_data_ok, s_data_ok && own);
         chk("r_m0_rdata", m0_rdata, (s_data_ok && !own) ? s_rdata : 32'h0);
         chk("r_m1_rdata", m1_rdata, (s_data_ok && own) ? s_rdata : 32'h0);
         chk("r_err", err, 0);

         if (s_data_ok) void'(exp_q.pop_front());
         if (acc) begin
            rr = win;
            ad = win ? m1_addr : m0_addr;
            if (win && m1_we) begin
               mem[ad] = merge(mem.exists(ad) ? mem[ad] : 32'h0, m1_wdata, m1_wem);
               rd = $urandom;
            end else begin
               rd = mem.exists(ad) ? mem[ad] : 32'h0;
            end
            exp_q.push_back('{owner: win, rdata: rd});
            if (win) a1 = 1'b0;
            else     a0 = 1'b0;
         end
         next_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
